// File: rtl/serial_to_parallel_sync_if.sv
// serial_to_parallel_sync_if: serial input and parallel word/status outputs of the aligner
interface serial_to_parallel_sync_if #(parameter int WIDTH = 8);
    logic             DATA_IN;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic             COM_DET;
    logic             ACTIVE;
    modport master (output DATA_IN, input DATA_OUT, VALID, COM_DET, ACTIVE);
    modport slave  (input DATA_IN, output DATA_OUT, VALID, COM_DET, ACTIVE);
endinterface

// File: rtl/serial_to_parallel_sync.sv
// serial_to_parallel_sync: MSB-first deserialiser that aligns on a comma word and
// delivers non-comma words once LOCK_COUNT aligned commas have been seen.
module serial_to_parallel_sync #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 16
) (
    input logic CLK,
    input logic RESET,
    serial_to_parallel_sync_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);
    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, dout_q, dout_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    com_q, com_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             valid_q, valid_d, comdet_q, comdet_d, active_q;
    logic             is_com, boundary;
    always_comb begin
        sreg_d   = {sreg_q[WIDTH-2:0], bus.DATA_IN};
        is_com   = sreg_d == COM_SYMBOL;
        boundary = bit_q == BW'(WIDTH - 1);
        state_d  = state_q;
        bit_d    = boundary ? '0 : bit_q + BW'(1);
        com_d    = com_q;
        gap_d    = gap_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        comdet_d = 1'b0;
        case (state_q)
            SEARCH: begin
                bit_d = '0;
                if (is_com) begin
                    com_d   = CW'(1);
                    gap_d   = '0;
                    state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: if (boundary) begin
                if (is_com) begin
                    comdet_d = 1'b1;
                    com_d    = com_q + CW'(1);
                    if (com_q + CW'(1) == CW'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        gap_d   = '0;
                    end
                end else begin
                    state_d = SEARCH;
                    com_d   = '0;
                end
            end
            LOCKED: if (boundary) begin
                if (is_com) begin
                    comdet_d = 1'b1;
                    gap_d    = '0;
                end else begin
                    dout_d  = sreg_d;
                    valid_d = 1'b1;
                    gap_d   = gap_q + GW'(1);
                    // the word that exhausts the gap budget is still delivered
                    if (gap_q + GW'(1) == GW'(MAX_GAP)) begin
                        state_d = SEARCH;
                        com_d   = '0;
                        gap_d   = '0;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= SEARCH;
            sreg_q   <= '0;
            bit_q    <= '0;
            com_q    <= '0;
            gap_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            comdet_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bit_q    <= bit_d;
            com_q    <= com_d;
            gap_q    <= gap_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            comdet_q <= comdet_d;
            active_q <= state_d == LOCKED;
        end
    end
    assign bus.DATA_OUT = dout_q;
    assign bus.VALID    = valid_q;
    assign bus.COM_DET  = comdet_q;
    assign bus.ACTIVE   = active_q;
endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// tb_serial_to_parallel_sync: scenario tasks with a delivered-word scoreboard over
// three configurations sharing one serial stream (default, MAX_GAP=4, 10-bit LOCK_COUNT=1).
module tb_serial_to_parallel_sync;
    logic       CLK = 1'b0, RESET = 1'b0, d = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [9:0] o_data;
    logic       o_valid, o_com, o_act;
    logic [9:0] sbq[$];
    int         n_cmp = 0, n_err = 0;
    always #5 CLK = ~CLK;
    serial_to_parallel_sync_if #(.WIDTH(8))  if0 ();
    serial_to_parallel_sync_if #(.WIDTH(8))  if1 ();
    serial_to_parallel_sync_if #(.WIDTH(10)) if2 ();
    assign if0.DATA_IN = d;
    assign if1.DATA_IN = d;
    assign if2.DATA_IN = d;
    serial_to_parallel_sync u0 (.CLK(CLK), .RESET(RESET), .bus(if0.slave));
    serial_to_parallel_sync #(.MAX_GAP(4)) u1 (.CLK(CLK), .RESET(RESET), .bus(if1.slave));
    serial_to_parallel_sync #(.WIDTH(10), .COM_SYMBOL(10'h17C), .LOCK_COUNT(1)) u2 (.CLK(CLK), .RESET(RESET), .bus(if2.slave));
    always_comb begin
        o_data  = sel == 2'd0 ? {2'b0, if0.DATA_OUT} : sel == 2'd1 ? {2'b0, if1.DATA_OUT} : if2.DATA_OUT;
        o_valid = sel == 2'd0 ? if0.VALID   : sel == 2'd1 ? if1.VALID   : if2.VALID;
        o_com   = sel == 2'd0 ? if0.COM_DET : sel == 2'd1 ? if1.COM_DET : if2.COM_DET;
        o_act   = sel == 2'd0 ? if0.ACTIVE  : sel == 2'd1 ? if1.ACTIVE  : if2.ACTIVE;
    end

    task automatic do_reset();
        RESET = 1'b0;
        d = 1'b0;
        sbq.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // drives n bits MSB first; any VALID must match the head of the scoreboard
    task automatic send_word(input logic [9:0] w, input int n);
        logic [9:0] e;
        for (int i = n - 1; i >= 0; i--) begin
            d = w[i];
            @(posedge CLK);
            #1;
            if (o_valid) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: DATA_OUT=%0h while no word was due", o_data);
                end else begin
                    e = sbq.pop_front();
                    if (o_data !== e) begin
                        n_err++;
                        $display("FAIL data_out: got %0h expected %0h", o_data, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        sel = 2'd0;
        do_reset();
        n_cmp++;
        if ({o_data, o_valid, o_com, o_act} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%0h v=%b c=%b a=%b expected all 0", o_data, o_valid, o_com, o_act);
        end
    endtask

    task automatic test_basic();
        logic [9:0] words[3] = '{10'h3D, 10'h0C, 10'h55};
        sel = 2'd0;
        do_reset();
        send_word(10'hF7, 8);
        send_word(10'hBC, 8);
        n_cmp++;
        if ({o_com, o_act} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_first_com: got com=%b act=%b expected 0 0", o_com, o_act);
        end
        for (int k = 2; k <= 4; k++) begin
            send_word(10'hBC, 8);
            n_cmp++;
            if ({o_com, o_act} !== {1'b1, k == 4}) begin
                n_err++;
                $display("FAIL basic_com%0d: got com=%b act=%b expected 1 %b", k, o_com, o_act, k == 4);
            end
        end
        foreach (words[i]) begin
            sbq.push_back(words[i]);
            send_word(words[i], 8);
            n_cmp++;
            if ({o_valid, o_act, o_com} !== 3'b110) begin
                n_err++;
                $display("FAIL basic_word%0d: got v=%b a=%b c=%b expected 1 1 0", i, o_valid, o_act, o_com);
            end
        end
        send_word(10'h0, 1);
        n_cmp++;
        if ({o_valid, o_data} !== {1'b0, 10'h55}) begin
            n_err++;
            $display("FAIL basic_hold: got v=%b data=%0h expected 0 55", o_valid, o_data);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL basic_pending: got %0d words outstanding expected 0", sbq.size());
        end
    endtask

    task automatic test_misaligned();
        sel = 2'd0;
        do_reset();
        send_word(10'($urandom_range(0, 7)), 3);
        repeat (4) send_word(10'hBC, 8);
        n_cmp++;
        if (o_act !== 1'b1) begin
            n_err++;
            $display("FAIL misaligned_lock: got act=%b expected 1", o_act);
        end
        sbq.push_back(10'hA5);
        send_word(10'hA5, 8);
        n_cmp++;
        if (o_valid !== 1'b1 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL misaligned_a5: got v=%b pending=%0d expected 1 0", o_valid, sbq.size());
        end
    endtask

    task automatic test_broken_sync();
        sel = 2'd0;
        do_reset();
        send_word(10'hBC, 8);
        send_word(10'hBC, 8);
        send_word(10'h3D, 8);
        n_cmp++;
        if ({o_act, o_com, o_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL broken_3d: got a=%b c=%b v=%b expected 0 0 0", o_act, o_com, o_valid);
        end
        repeat (4) send_word(10'hBC, 8);
        n_cmp++;
        if (o_act !== 1'b1) begin
            n_err++;
            $display("FAIL broken_relock: got act=%b expected 1", o_act);
        end
        sbq.push_back(10'h11);
        send_word(10'h11, 8);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL broken_pending: got %0d words outstanding expected 0", sbq.size());
        end
    endtask

    task automatic test_gap_loss();
        sel = 2'd1;
        do_reset();
        repeat (4) send_word(10'hBC, 8);
        for (int k = 1; k <= 4; k++) begin
            sbq.push_back(10'(k));
            send_word(10'(k), 8);
            n_cmp++;
            if ({o_valid, o_act} !== {1'b1, k != 4}) begin
                n_err++;
                $display("FAIL gap_word%0d: got v=%b a=%b expected 1 %b", k, o_valid, o_act, k != 4);
            end
        end
        send_word(10'h05, 8);
        n_cmp++;
        if ({o_valid, o_act, sbq.size() == 0} !== 3'b001) begin
            n_err++;
            $display("FAIL gap_after_loss: got v=%b a=%b pending=%0d expected 0 0 0", o_valid, o_act, sbq.size());
        end
        do_reset();
        repeat (4) send_word(10'hBC, 8);
        sbq.push_back(10'h01);
        send_word(10'h01, 8);
        send_word(10'hBC, 8);
        n_cmp++;
        if (o_com !== 1'b1) begin
            n_err++;
            $display("FAIL gap_mid_com: got com=%b expected 1", o_com);
        end
        for (int k = 2; k <= 4; k++) begin
            sbq.push_back(10'(k));
            send_word(10'(k), 8);
        end
        n_cmp++;
        if (o_act !== 1'b1 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL gap_reset_by_com: got act=%b pending=%0d expected 1 0", o_act, sbq.size());
        end
    endtask

    task automatic test_wide_single_lock();
        sel = 2'd2;
        do_reset();
        send_word(10'h17C, 10);
        n_cmp++;
        if ({o_act, o_com} !== 2'b10) begin
            n_err++;
            $display("FAIL wide_lock: got a=%b c=%b expected 1 0", o_act, o_com);
        end
        sbq.push_back(10'h2A5);
        send_word(10'h2A5, 10);
        n_cmp++;
        if (o_valid !== 1'b1 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL wide_word: got v=%b pending=%0d expected 1 0", o_valid, sbq.size());
        end
    endtask

    task automatic test_reset_mid_word();
        sel = 2'd0;
        do_reset();
        repeat (4) send_word(10'hBC, 8);
        sbq.push_back(10'h5A);
        send_word(10'h5A, 8);
        send_word(10'h15, 5);
        n_cmp++;
        if ({o_act, o_data} !== {1'b1, 10'h5A}) begin
            n_err++;
            $display("FAIL midrst_before: got a=%b data=%0h expected 1 5a", o_act, o_data);
        end
        RESET = 1'b0;
        #1;
        n_cmp++;
        if ({o_data, o_valid, o_com, o_act} !== 13'd0) begin
            n_err++;
            $display("FAIL midrst_async: got data=%0h v=%b c=%b a=%b expected all 0", o_data, o_valid, o_com, o_act);
        end
        sbq.delete();
        @(negedge CLK);
        RESET = 1'b1;
        send_word(10'h3D, 8);
        send_word(10'h0C, 8);
        n_cmp++;
        if (o_act !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_after: got act=%b expected 0", o_act);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_broken_sync();
        test_gap_loss();
        test_wide_single_lock();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel_sync.md
Name: serial_to_parallel_sync

Overview:
- Parametrised successor to the fixed 8-bit serial-to-parallel converter.
- Takes one serial bit per clock, MSB-first, and hunts for a comma (COM) symbol at any bit offset.
- Locks word alignment after LOCK_COUNT consecutive aligned COMs, then delivers non-COM words as WIDTH-bit parallel words with a valid strobe.
- Drops lock when no COM is seen for MAX_GAP consecutive words. Sits on the receive side, after the serial line and before the byte/lane logic.

Parameters:
WIDTH, 8, parallel word width in bits (>=2)
COM_SYMBOL, 8'hBC, alignment/comma word (WIDTH bits)
LOCK_COUNT, 4, consecutive aligned COMs required to reach lock (>=1)
MAX_GAP, 16, consecutive non-COM words tolerated while locked before lock is lost (>=1)

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  asynchronous, active-low reset (RESET=0 resets immediately; released synchronously by the environment)
DATA_IN  input  1  serial data, sampled every rising edge, MSB of each word first
DATA_OUT  output  WIDTH  last delivered word; holds its value between VALID pulses
VALID  output  1  one-cycle pulse when DATA_OUT carries a new non-COM word
COM_DET  output  1  one-cycle pulse when an aligned COM is received (SYNC or LOCKED state)
ACTIVE  output  1  high while in LOCKED state

Behaviour:
- Reset (RESET=0): shift register=0, bit_cnt=0, com_cnt=0, gap_cnt=0, state=SEARCH, DATA_OUT=0, VALID=0, COM_DET=0, ACTIVE=0. Reset takes effect mid-word or mid-lock with no partial output.
- Every edge out of reset: sreg_next={sreg[WIDTH-2:0],DATA_IN}; sreg<=sreg_next. All decisions below use sreg_next; outputs are registered, so results appear in the cycle after the edge that samples the word's last bit.
- bit_cnt counts 0..WIDTH-1. A word boundary is an edge where bit_cnt==WIDTH-1; bit_cnt then wraps to 0.
- SEARCH: bit_cnt is ignored. Each edge, if sreg_next==COM_SYMBOL then: bit_cnt<=0, com_cnt<=1, COM_DET is not pulsed, and the next state is LOCKED if LOCK_COUNT==1, else SYNC. Otherwise stay in SEARCH.
- SYNC, non-boundary edge: bit_cnt++.
- SYNC, boundary edge with sreg_next==COM: COM_DET=1 and com_cnt++. When the incremented count equals LOCK_COUNT, go to LOCKED with gap_cnt=0.
- SYNC, boundary edge with a non-COM word: go to SEARCH, com_cnt=0, no VALID. A COM at a new offset is only found via SEARCH, starting from the next edge.
- LOCKED, boundary edge:
  - COM word: COM_DET=1, gap_cnt=0, VALID=0, DATA_OUT unchanged.
  - Non-COM word: DATA_OUT<=sreg_next, VALID=1, gap_cnt++.
  - If the incremented gap_cnt equals MAX_GAP: that word is still delivered (VALID=1), and on the same edge the state goes to SEARCH, so ACTIVE falls together with that VALID pulse. com_cnt and gap_cnt clear.
- ACTIVE is registered and equals (state==LOCKED). It rises on the edge that accepts the LOCK_COUNT-th COM.
- VALID and COM_DET are never high together. Neither is ever high in SEARCH.
- Counter widths: com_cnt is $clog2(LOCK_COUNT+1); gap_cnt is $clog2(MAX_GAP+1). Neither counter saturates past its terminal value.

Test Plan:
- WIDTH=8, COM=BC, LOCK_COUNT=4: after reset send F7, then BC x4, then 3D, 0C, 55 → COM_DET pulses on BCs #2–#4. ACTIVE rises after the last bit of BC #4. VALID pulses 3 times with DATA_OUT=3D, 0C, 55, each one cycle after that word's 8th bit. DATA_OUT holds 55 afterwards.
- Misaligned start: 3 random bits, then BC x4, then A5 → lock is achieved and DATA_OUT=A5 with VALID=1. No VALID during the preamble or the BCs.
- Broken sync: BC, BC, 3D, then BC x4, then 11 → returns to SEARCH at the 3D boundary with ACTIVE=0 and no VALID for 3D. Relocks on the later BCs and delivers 11.
- Loss of lock, MAX_GAP=4: lock, then send 01, 02, 03, 04, 05 → VALID for 01–04. ACTIVE falls on the same edge as the 04 VALID. No VALID for 05. A BC mid-run (01, BC, 02, 03, 04) resets the gap and keeps ACTIVE=1.
- LOCK_COUNT=1, WIDTH=10, COM=10'h17C → a single 17C sets ACTIVE, and the next 10-bit word is delivered.
- Reset mid-word while locked: assert RESET=0 after 5 bits of a data word → all outputs go to 0 immediately. After release with no COM, ACTIVE stays 0.
